// File: rtl/mux_par2ser_pkg.sv
// Shared FFT serializer definitions: word width default, order modes, FSM encoding.
package mux_par2ser_pkg;

  localparam int WORD_SIZE_DEF = 16;

  localparam logic MODE_NATURAL = 1'b0;
  localparam logic MODE_BITREV  = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_rev.sv
// Reverses the bit order of an index; shared with the FFT address generators.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module bit_rev #(
  parameter int W = 2
) (
  input  logic [W-1:0] idx,
  input  logic [W-1:0] dummy_unused_never,
  output logic [W-1:0] rev
);

  always_comb begin
    rev = '0;
    for (int i = 0; i < W; i++) begin
      rev[i] = idx[W-1-i];
    end
  end

endmodule

// File: rtl/mux_par2ser.sv
// Captures CHANNELS parallel words per handshake and streams them out one per beat, natural or bit-reversed.
// Latency: first word valid the cycle after capture; CHANNELS beats per frame, zero-bubble frame chaining.
// Backpressure: out_ready low freezes the current word and index; in_ready only opens in IDLE or on the accepted last beat.
module mux_par2ser
  import mux_par2ser_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int CHANNELS  = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS*WORD_SIZE-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  output logic [WORD_SIZE-1:0]          out_data,
  output logic [SEL_W-1:0]              out_sel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     cnt_rev;
  logic                 mode_q;
  logic                 load;
  logic [WORD_SIZE-1:0] buf_q [CHANNELS];

  bit_rev #(.W(SEL_W)) u_bit_rev (
    .idx                (cnt_q),
    .dummy_unused_never (cnt_q),
    .rev                (cnt_rev)
  );

  assign out_valid = (state_q == ST_SHIFT);
  assign busy      = (state_q == ST_SHIFT);
  assign out_last  = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
  // Combinational out_ready -> in_ready lets the next frame load on the last beat.
  assign in_ready  = (state_q == ST_IDLE) || (out_last && out_ready);
  assign out_sel   = (mode_q == MODE_BITREV) ? cnt_rev : cnt_q;
  assign out_data  = buf_q[out_sel];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (out_ready) begin
          if (cnt_q != LAST_IDX) begin
            cnt_d = cnt_q + SEL_W'(1);
          end else if (in_valid) begin
            load  = 1'b1;
            cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_NATURAL;
      for (int k = 0; k < CHANNELS; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        mode_q <= in_mode;
        for (int k = 0; k < CHANNELS; k++) begin
          buf_q[k] <= in_data[k*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

endmodule
